mmm_pe_sequencer: RTL and testbench

//  Parametrised control sequencer for one scalable radix-4 Montgomery PE; next generation of the hard-coded PE controller.

---
 rtl/mmm_pe_sequencer_if.sv | 44 ++++
 rtl/mmm_pe_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mmm_pe_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmm_pe_sequencer_if.sv
// rtl/mmm_pe_sequencer_if.sv - control/status bundle between a Montgomery PE sequencer and its environment
//
// Purpose: groups the enable/back-pressure/config inputs and the phase, index
//          and strobe outputs of mmm_pe_sequencer into one interface.
// Ports (signals):
//   E_IN, HOLD, NWORDS, STALL_CYC           environment -> sequencer
//   PHASE, DIG_IDX, WORD_IDX, INIT, Q_WR,
//   CARRY_WR, PASS_WORD, E_OUT, DONE,
//   PASS_CNT, ERR                           sequencer -> environment
// Modports: master drives the inputs (upstream PE / bench), slave is the sequencer.
interface mmm_pe_sequencer_if #(
    parameter int DW  = 3,
    parameter int NWW = 7,
    parameter int SW  = 8,
    parameter int PW  = 16
);
    logic           E_IN;
    logic           HOLD;
    logic [NWW-1:0] NWORDS;
    logic [SW-1:0]  STALL_CYC;
    logic [1:0]     PHASE;
    logic [DW-1:0]  DIG_IDX;
    logic [NWW-1:0] WORD_IDX;
    logic           INIT;
    logic           Q_WR;
    logic           CARRY_WR;
    logic           PASS_WORD;
    logic           E_OUT;
    logic           DONE;
    logic [PW-1:0]  PASS_CNT;
    logic           ERR;

    modport master (
        output E_IN, HOLD, NWORDS, STALL_CYC,
        input  PHASE, DIG_IDX, WORD_IDX, INIT, Q_WR, CARRY_WR,
               PASS_WORD, E_OUT, DONE, PASS_CNT, ERR
    );

    modport slave (
        input  E_IN, HOLD, NWORDS, STALL_CYC,
        output PHASE, DIG_IDX, WORD_IDX, INIT, Q_WR, CARRY_WR,
               PASS_WORD, E_OUT, DONE, PASS_CNT, ERR
    );
endinterface

// File: rtl/mmm_pe_sequencer.sv
// rtl/mmm_pe_sequencer.sv - control sequencer for one scalable radix-4 Montgomery PE
//
// Purpose: steps a PE through IDLE -> TASK_X -> TASK_Y (NWORDS words) -> STALL
//          -> TASK_X ..., generating digit/word indices, phase, the datapath
//          strobes and the downstream enable. Counts completed sweeps and flags
//          illegal word counts.
// Ports:
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset
//   bus    mmm_pe_sequencer_if.slave
//          in : E_IN (low = flush to IDLE), HOLD (freeze), NWORDS, STALL_CYC
//          out: PHASE, DIG_IDX, WORD_IDX, INIT, Q_WR, CARRY_WR, PASS_WORD,
//               E_OUT, DONE, PASS_CNT, ERR
module mmm_pe_sequencer #(
    parameter int K        = 1024,
    parameter int W        = 16,
    parameter int DIGITS   = W / 2 - 1,
    parameter int MAXWORDS = K / W,
    parameter int DW       = $clog2(DIGITS),
    parameter int NWW      = $clog2(MAXWORDS) + 1,
    parameter int SW       = 8,
    parameter int PW       = 16
) (
    input  logic               CLK,
    input  logic               RST,
    mmm_pe_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TASKX = 2'b01,
        S_TASKY = 2'b10,
        S_STALL = 2'b11
    } phase_t;

    localparam logic [DW-1:0]  DIG_LAST = DW'(DIGITS - 1);
    localparam logic [NWW-1:0] NW_MAX   = NWW'(MAXWORDS);

    phase_t          phase_q, phase_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [NWW-1:0]  word_q, word_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            eout_q, eout_d;
    logic [PW-1:0]   pass_q, pass_d;
    logic            err_q, err_d;
    logic [NWW-1:0]  nw_sh_q, nw_sh_d;
    logic [SW-1:0]   st_sh_q, st_sh_d;

    logic            dig_last;
    logic            active;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q <= S_IDLE;
            dig_q   <= '0;
            word_q  <= '0;
            stall_q <= '0;
            eout_q  <= 1'b0;
            pass_q  <= '0;
            err_q   <= 1'b0;
            nw_sh_q <= '0;
            st_sh_q <= '0;
        end else begin
            phase_q <= phase_d;
            dig_q   <= dig_d;
            word_q  <= word_d;
            stall_q <= stall_d;
            eout_q  <= eout_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            nw_sh_q <= nw_sh_d;
            st_sh_q <= st_sh_d;
        end
    end

    assign dig_last = (dig_q == DIG_LAST);

    always_comb begin
        phase_d = phase_q;
        dig_d   = dig_q;
        word_d  = word_q;
        stall_d = stall_q;
        eout_d  = eout_q;
        pass_d  = pass_q;
        err_d   = err_q;
        nw_sh_d = nw_sh_q;
        st_sh_d = st_sh_q;

        if (!bus.E_IN) begin
            // Flush beats HOLD and also swallows a coincident sweep completion.
            phase_d = S_IDLE;
            dig_d   = '0;
            word_d  = '0;
            stall_d = '0;
            eout_d  = 1'b0;
        end else if (!bus.HOLD) begin
            unique case (phase_q)
                S_IDLE: begin
                    nw_sh_d = bus.NWORDS;
                    st_sh_d = bus.STALL_CYC;
                    if (bus.NWORDS == '0 || bus.NWORDS > NW_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        phase_d = S_TASKX;
                        dig_d   = '0;
                    end
                end
                S_TASKX: begin
                    if (dig_last) begin
                        eout_d  = 1'b1;
                        word_d  = nw_sh_q;
                        dig_d   = '0;
                        phase_d = S_TASKY;
                    end else begin
                        dig_d = dig_q + DW'(1);
                    end
                end
                S_TASKY: begin
                    if (dig_last) begin
                        dig_d = '0;
                        if (word_q > NWW'(1)) begin
                            word_d = word_q - NWW'(1);
                        end else begin
                            word_d = '0;
                            pass_d = pass_q + PW'(1);
                            if (st_sh_q != '0) begin
                                phase_d = S_STALL;
                                stall_d = st_sh_q;
                            end else begin
                                phase_d = S_TASKX;
                            end
                        end
                    end else begin
                        dig_d = dig_q + DW'(1);
                    end
                end
                S_STALL: begin
                    // stall_q was loaded with the shadow length on entry, so
                    // the phase lasts exactly that many cycles.
                    if (stall_q <= SW'(1)) begin
                        stall_d = '0;
                        dig_d   = '0;
                        phase_d = S_TASKX;
                    end else begin
                        stall_d = stall_q - SW'(1);
                    end
                end
                default: phase_d = S_IDLE;
            endcase
        end
    end

    // Strobes decode registered state only; HOLD masks them so a frozen
    // cycle never writes the register files twice.
    assign active = !bus.HOLD && (phase_q == S_TASKX || phase_q == S_TASKY);

    assign bus.PHASE     = phase_q;
    assign bus.DIG_IDX   = dig_q;
    assign bus.WORD_IDX  = word_q;
    assign bus.INIT      = active && (dig_q == '0);
    assign bus.Q_WR      = active && (phase_q == S_TASKX);
    assign bus.CARRY_WR  = active;
    assign bus.PASS_WORD = active && dig_last;
    assign bus.E_OUT     = eout_q;
    assign bus.DONE      = active && (phase_q == S_TASKY) && dig_last && (word_q == NWW'(1));
    assign bus.PASS_CNT  = pass_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_mmm_pe_sequencer.sv
// tb/tb_mmm_pe_sequencer.sv - self-checking bench for mmm_pe_sequencer
module tb_mmm_pe_sequencer;
    localparam int D    = 7;
    localparam int MAXW = 64;
    // bit positions inside the packed observation vector
    localparam int B_EOUT = 18;
    localparam int B_DONE = 17;
    localparam int B_CW   = 20;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mmm_pe_sequencer_if bus ();

    mmm_pe_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference: a pass is a timeline of P = D*(1+n)+s cycles; the position
    // on that timeline fully determines the expected outputs.
    bit m_run;
    int m_t, m_n, m_s, m_pass;
    bit m_err;

    function automatic logic [34:0] pack_obs();
        return {bus.PHASE, bus.DIG_IDX, bus.WORD_IDX, bus.INIT, bus.Q_WR, bus.CARRY_WR,
                bus.PASS_WORD, bus.E_OUT, bus.DONE, bus.PASS_CNT, bus.ERR};
    endfunction

    function automatic logic [34:0] model_expect(input bit hold);
        int p, pos, ph, dg, wd;
        bit act, ini, qw, cw, pw, eo, dn;
        ph = 0; dg = 0; wd = 0;
        act = 0; ini = 0; qw = 0; cw = 0; pw = 0; eo = 0; dn = 0;
        if (m_run) begin
            p   = D * (1 + m_n) + m_s;
            pos = m_t % p;
            eo  = (m_t >= D);
            if (pos < D) begin
                ph = 1; dg = pos;
            end else if (pos < D * (1 + m_n)) begin
                ph = 2; dg = (pos - D) % D; wd = m_n - (pos - D) / D;
            end else begin
                ph = 3;
            end
            act = !hold && (ph == 1 || ph == 2);
            ini = act && dg == 0;
            pw  = act && dg == D - 1;
            cw  = act;
            qw  = act && ph == 1;
            dn  = act && ph == 2 && pos == D * (1 + m_n) - 1;
        end
        return {ph[1:0], dg[2:0], wd[6:0], ini, qw, cw, pw, eo, dn, m_pass[15:0], m_err};
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_n = 1; m_s = 0; m_pass = 0; m_err = 0;
    endtask

    task automatic model_step();
        int p;
        if (RST) begin
            model_reset();
        end else if (!bus.E_IN) begin
            m_run = 0; m_t = 0;
        end else if (!bus.HOLD) begin
            if (!m_run) begin
                if (bus.NWORDS == 0 || int'(bus.NWORDS) > MAXW) begin
                    m_err = 1;
                end else begin
                    m_run = 1; m_t = 0; m_n = int'(bus.NWORDS); m_s = int'(bus.STALL_CYC);
                end
            end else begin
                p = D * (1 + m_n) + m_s;
                if (m_t % p == D * (1 + m_n) - 1) m_pass++;
                m_t++;
            end
        end
    endtask

    // Sample at the falling edge, advance the model at the rising edge,
    // return 1 time unit after it so stimulus changes are away from edges.
    task automatic tick(output logic [34:0] o, output logic [34:0] e);
        @(negedge CLK);
        o = pack_obs();
        e = model_expect(bus.HOLD);
        @(posedge CLK);
        model_step();
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bus.E_IN = 1'b0; bus.HOLD = 1'b0;
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [34:0] o, e;
        bus.E_IN = 1'b1; bus.HOLD = 1'b0; bus.NWORDS = 7'd3; bus.STALL_CYC = 8'd2;
        RST = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        checks++;
        if (o !== 35'd0) begin failures++; $display("FAIL reset_zero got=%h exp=0", o); end
        bus.E_IN = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    task automatic test_basic_pass();
        logic [34:0] o, e;
        int start, eo_c, done_c, tx2, prev_ph, ph;
        do_reset();
        bus.NWORDS = 7'd4; bus.STALL_CYC = 8'd7; bus.E_IN = 1'b1;
        start = -1; eo_c = -1; done_c = -1; tx2 = -1; prev_ph = 0;
        for (int i = 0; i < 60; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL basic_pass cyc=%0d got=%h exp=%h", cyc, o, e); end
            ph = int'(o[34:33]);
            if (start < 0 && ph == 1) start = i;
            if (start >= 0) begin
                if (eo_c < 0 && o[B_EOUT]) eo_c = i - start;
                if (done_c < 0 && o[B_DONE]) done_c = i - start;
                if (tx2 < 0 && prev_ph == 3 && ph == 1) tx2 = i - start;
            end
            prev_ph = ph;
        end
        checks++;
        if (eo_c != 7) begin failures++; $display("FAIL basic_eout_latency got=%0d exp=7", eo_c); end
        checks++;
        if (done_c != 34) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=34", done_c); end
        checks++;
        if (tx2 != 42) begin failures++; $display("FAIL basic_period got=%0d exp=42", tx2); end
    endtask

    task automatic test_alternate();
        logic [34:0] o, e;
        int start, ndone, pc;
        do_reset();
        bus.NWORDS = 7'd1; bus.STALL_CYC = 8'd0; bus.E_IN = 1'b1;
        start = -1; ndone = 0; pc = -1;
        for (int i = 0; i < 160; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL alternate cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (start < 0 && o[34:33] == 2'b01) start = i;
            if (start >= 0 && i - start < 140 && o[B_DONE]) ndone++;
            if (start >= 0 && i - start == 140) pc = int'(o[16:1]);
        end
        checks++;
        if (ndone != 10) begin failures++; $display("FAIL alternate_done_count got=%0d exp=10", ndone); end
        checks++;
        if (pc != 10) begin failures++; $display("FAIL alternate_pass_cnt got=%0d exp=10", pc); end
    endtask

    task automatic test_err();
        logic [34:0] o, e;
        do_reset();
        bus.NWORDS = 7'd0; bus.STALL_CYC = 8'd1; bus.E_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL err_zero cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        checks++;
        if (o[0] !== 1'b1 || o[34:33] !== 2'b00 || o[B_EOUT] !== 1'b0) begin
            failures++; $display("FAIL err_zero_flag got=%h exp=err=1,idle,eout=0", o);
        end
        do_reset();
        bus.NWORDS = 7'd65; bus.E_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL err_big cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        checks++;
        if (o[0] !== 1'b1 || o[34:33] !== 2'b00) begin
            failures++; $display("FAIL err_big_flag got=%h exp=err=1,idle", o);
        end
        bus.NWORDS = 7'd64;
        for (int i = 0; i < 12; i++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL err_sticky cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        checks++;
        if (o[0] !== 1'b1 || o[34:33] === 2'b00) begin
            failures++; $display("FAIL err_sticky_flag got=%h exp=err=1,running", o);
        end
        do_reset();
        tick(o, e);
        checks++;
        if (o[0] !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", o[0]); end
    endtask

    task automatic test_hold();
        logic [34:0] o, e;
        int start, done_c, i;
        bit armed;
        do_reset();
        bus.NWORDS = 7'd2; bus.STALL_CYC = 8'd0; bus.E_IN = 1'b1;
        start = -1; done_c = -1; armed = 0; i = 0;
        while (i < 60 && done_c < 0) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (start < 0 && o[34:33] == 2'b01) start = i;
            if (start >= 0 && o[B_DONE]) done_c = i - start;
            i++;
            if (!armed && o[34:33] == 2'b10 && o[32:30] == 3'd2) begin
                armed = 1;
                bus.HOLD = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    tick(o, e);
                    checks++;
                    if (o !== e) begin failures++; $display("FAIL hold_frozen cyc=%0d got=%h exp=%h", cyc, o, e); end
                    checks++;
                    if (o[32:30] !== 3'd3 || o[B_CW] !== 1'b0) begin
                        failures++; $display("FAIL hold_dig got=%h exp=dig3,no strobes", o);
                    end
                    i++;
                end
                bus.HOLD = 1'b0;
            end
        end
        checks++;
        if (done_c != 25) begin failures++; $display("FAIL hold_done_delay got=%0d exp=25", done_c); end
    endtask

    task automatic test_flush();
        logic [34:0] o, e;
        int i, pc_before, ty_word;
        bit hit;
        do_reset();
        bus.NWORDS = 7'd3; bus.STALL_CYC = 8'd2; bus.E_IN = 1'b1;
        hit = 0; i = 0;
        while (i < 200 && !hit) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL flush_pre cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (o[16:1] == 16'd1 && o[34:33] == 2'b10 && o[29:23] == 7'd2) hit = 1;
            i++;
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL flush_reach got=timeout exp=TASK_Y word 2"); end
        pc_before = int'(o[16:1]);
        bus.E_IN = 1'b0;
        tick(o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL flush_cycle cyc=%0d got=%h exp=%h", cyc, o, e); end
        bus.E_IN = 1'b1; bus.NWORDS = 7'd2;
        tick(o, e);
        checks++;
        if (o[34:33] !== 2'b00 || o[B_EOUT] !== 1'b0 || int'(o[16:1]) != pc_before) begin
            failures++; $display("FAIL flush_idle got=%h exp=idle,eout0,pass=%0d", o, pc_before);
        end
        ty_word = -1; i = 0;
        while (i < 40 && ty_word < 0) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL flush_restart cyc=%0d got=%h exp=%h", cyc, o, e); end
            if (o[34:33] == 2'b10) ty_word = int'(o[29:23]);
            i++;
        end
        checks++;
        if (ty_word != 2) begin failures++; $display("FAIL flush_new_nwords got=%0d exp=2", ty_word); end
    endtask

    task automatic test_async_reset();
        logic [34:0] o, e;
        int i;
        do_reset();
        bus.NWORDS = 7'd1; bus.STALL_CYC = 8'd20; bus.E_IN = 1'b1;
        i = 0;
        o = '0;
        while (i < 60 && o[34:33] != 2'b11) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL areset_pre cyc=%0d got=%h exp=%h", cyc, o, e); end
            i++;
        end
        for (int k = 0; k < 2; k++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL areset_stall cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        checks++;
        if (o[34:33] !== 2'b11 || o[16:1] !== 16'd1) begin
            failures++; $display("FAIL areset_in_stall got=%h exp=stall,pass1", o);
        end
        // mid-cycle, between edges
        #2;
        RST = 1'b1;
        #1;
        o = pack_obs();
        checks++;
        if (o !== 35'd0) begin failures++; $display("FAIL areset_immediate got=%h exp=0", o); end
        model_reset();
        for (int k = 0; k < 2; k++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL areset_hold cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
        RST = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL areset_release cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    task automatic test_random();
        logic [34:0] o, e;
        do_reset();
        bus.E_IN = 1'b1; bus.NWORDS = 7'd2; bus.STALL_CYC = 8'd3;
        for (int i = 0; i < 4000; i++) begin
            bus.E_IN = ($urandom_range(0, 79) != 0);
            bus.HOLD = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 9) == 0) bus.NWORDS = 7'($urandom_range(60, 66));
                else                           bus.NWORDS = 7'($urandom_range(0, 5));
                bus.STALL_CYC = 8'($urandom_range(0, 9));
            end
            tick(o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e); end
        end
    endtask

    initial begin
        bus.E_IN = 1'b0; bus.HOLD = 1'b0; bus.NWORDS = 7'd1; bus.STALL_CYC = 8'd0;
        model_reset();
        test_reset();
        test_basic_pass();
        test_alternate();
        test_err();
        test_hold();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
